write_mc: RTL and testbench

- Multi-channel, parametrised successor of the single-lane write stage.
- Accepts packed NUM_CH-lane words from the upstream pipeline.
- Clips each lane to a signed [min_clip, max_clip] range and narrows it to OUTPUT_DATA_WIDTH, then buffers the words in an internal FIFO of depth 2^LOG_FIFO_DEPTH.
- Writes the words to a block-RAM port with generated addresses: base + per-iteration stride + linear offset. Write issue is gated by a downstream grant.

---
 rtl/write_mc_if.sv | 38 +++
 rtl/write_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_write_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_mc_if.sv
// -----------------------------------------------------------------------------
// write_mc_if
// Stream/bus bundle for the multi-channel write stage.
//   data_in     packed NUM_CH x INPUT_DATA_WIDTH lanes from upstream
//   valid_in    data_in valid
//   avail_out   write stage can accept a word this cycle
//   ready_in    downstream grant for a block-RAM write this cycle
//   data_out    packed NUM_CH x OUTPUT_DATA_WIDTH clipped lanes
//   address_out block-RAM write address
//   valid_out   block-RAM write enable
// Modports:
//   slave  - the write stage itself
//   master - the environment (upstream producer + RAM/arbiter side)
// -----------------------------------------------------------------------------
interface write_mc_if #(
  parameter int NUM_CH            = 8,
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int LOG_MAX_ADDRESS   = 16
);
  logic [NUM_CH*INPUT_DATA_WIDTH-1:0]  data_in;
  logic                                valid_in;
  logic                                avail_out;
  logic                                ready_in;
  logic [NUM_CH*OUTPUT_DATA_WIDTH-1:0] data_out;
  logic [LOG_MAX_ADDRESS-1:0]          address_out;
  logic                                valid_out;

  modport slave (
    input  data_in, valid_in, ready_in,
    output avail_out, data_out, address_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  avail_out, data_out, address_out, valid_out
  );
endinterface

// File: rtl/write_mc.sv
// -----------------------------------------------------------------------------
// write_mc
// Multi-channel write stage. Accepts packed NUM_CH-lane words, clips each lane
// to the signed range [min_clip, max_clip], narrows it to OUTPUT_DATA_WIDTH,
// buffers the words in a 2^LOG_FIFO_DEPTH FIFO and writes them to a block-RAM
// port at base + iteration*stride + offset, gated by a downstream grant.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous, active-low reset
//   configure           one-cycle configuration strobe (honoured in IDLE only)
//   num_iters           number of iterations
//   num_reads_per_iter  words accepted per iteration
//   base_address        first write address
//   iter_stride         address distance between iteration starts
//   min_clip, max_clip  signed clip bounds applied to every lane
//   bus (slave)         data_in/valid_in/avail_out, ready_in/data_out/
//                       address_out/valid_out (see write_mc_if)
//   busy_out            high while RUN or DRAIN
//   done_out            one-cycle completion pulse
//   clip_count_out      (WRITE_MC_CLIP_COUNT_EN only) saturating count of
//                       clipped lanes since the last configure
//
// Optional feature macro: WRITE_MC_CLIP_COUNT_EN
// -----------------------------------------------------------------------------
module write_mc #(
  parameter int NUM_CH                 = 8,
  parameter int INPUT_DATA_WIDTH       = 16,
  parameter int OUTPUT_DATA_WIDTH      = 8,
  parameter int LOG_FIFO_DEPTH         = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                configure,
  input  logic [LOG_MAX_ITERS-1:0]            num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]          base_address,
  input  logic [LOG_MAX_ADDRESS-1:0]          iter_stride,
  input  logic signed [OUTPUT_DATA_WIDTH-1:0] min_clip,
  input  logic signed [OUTPUT_DATA_WIDTH-1:0] max_clip,
  write_mc_if.slave                           bus,
  output logic                                busy_out,
  output logic                                done_out
`ifdef WRITE_MC_CLIP_COUNT_EN
  ,
  output logic [LOG_MAX_ADDRESS-1:0]          clip_count_out
`endif
);

  localparam int DEPTH  = 1 << LOG_FIFO_DEPTH;
  localparam int WORD_W = NUM_CH * OUTPUT_DATA_WIDTH;
  localparam int IW     = INPUT_DATA_WIDTH;
  localparam int OW     = OUTPUT_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Lower bound is tested first, so an inverted range (min > max) favours min.
  function automatic logic [OW-1:0] clip_lane(
    input logic signed [IW-1:0] v,
    input logic signed [OW-1:0] lo,
    input logic signed [OW-1:0] hi
  );
    logic signed [IW-1:0] lo_x;
    logic signed [IW-1:0] hi_x;
    logic signed [IW-1:0] r;
    lo_x = IW'(lo);
    hi_x = IW'(hi);
    if (v < lo_x)      r = lo_x;
    else if (v > hi_x) r = hi_x;
    else               r = v;
    return r[OW-1:0];
  endfunction

  state_t state_q, state_d;

  logic [LOG_MAX_ITERS-1:0]          niters_q, it_cnt_q;
  logic [LOG_MAX_READS_PER_ITER-1:0] nreads_q, rd_cnt_q, wr_cnt_q;
  logic [LOG_MAX_ADDRESS-1:0]        stride_q, iter_base_q, cur_addr_q, addr_out_q;
  logic signed [OW-1:0]              min_q, max_q;

  logic [WORD_W-1:0]         mem [DEPTH];
  logic [LOG_FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_FIFO_DEPTH:0]   count_q;

  logic [WORD_W-1:0] data_out_q;
  logic              valid_out_q;
  logic              done_q, done_d;
  logic              degen_q;

  logic              fifo_full, fifo_empty;
  logic              cfg_take, degenerate;
  logic              accept, pop;
  logic              rd_last, it_last, wr_last;
  logic [WORD_W-1:0] clip_word;

  assign fifo_full  = (count_q == (LOG_FIFO_DEPTH+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cfg_take   = (state_q == IDLE) && configure;
  assign degenerate = (num_iters == '0) || (num_reads_per_iter == '0);

  assign bus.avail_out = (state_q == RUN) && !fifo_full;
  assign accept        = bus.valid_in && bus.avail_out;
  // No fall-through: an empty FIFO never pops, even if a push lands this cycle.
  assign pop           = (state_q != IDLE) && !fifo_empty && bus.ready_in;

  assign rd_last = (rd_cnt_q == nreads_q - LOG_MAX_READS_PER_ITER'(1));
  assign it_last = (it_cnt_q == niters_q - LOG_MAX_ITERS'(1));
  assign wr_last = (wr_cnt_q == nreads_q - LOG_MAX_READS_PER_ITER'(1));

  always_comb begin
    clip_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      clip_word[k*OW +: OW] = clip_lane($signed(bus.data_in[k*IW +: IW]), min_q, max_q);
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = degen_q;
    unique case (state_q)
      IDLE:  if (cfg_take && !degenerate) state_d = RUN;
      RUN:   if (accept && rd_last && it_last) state_d = DRAIN;
      // An empty FIFO implies no pop, so the final write has already issued.
      DRAIN: if (fifo_empty) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage: FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= clip_word;
  end

  // ---- stage: control, counters, address generation, write port ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      niters_q    <= '0;
      nreads_q    <= '0;
      stride_q    <= '0;
      min_q       <= '0;
      max_q       <= '0;
      it_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      iter_base_q <= '0;
      cur_addr_q  <= '0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
      degen_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      degen_q     <= cfg_take && degenerate;
      valid_out_q <= pop;

      if (cfg_take) begin
        niters_q    <= num_iters;
        nreads_q    <= num_reads_per_iter;
        stride_q    <= iter_stride;
        min_q       <= min_clip;
        max_q       <= max_clip;
        it_cnt_q    <= '0;
        rd_cnt_q    <= '0;
        wr_cnt_q    <= '0;
        iter_base_q <= base_address;
        cur_addr_q  <= base_address;
      end

      if (accept) begin
        wr_ptr_q <= wr_ptr_q + LOG_FIFO_DEPTH'(1);
        if (rd_last) begin
          rd_cnt_q <= '0;
          it_cnt_q <= it_cnt_q + LOG_MAX_ITERS'(1);
        end else begin
          rd_cnt_q <= rd_cnt_q + LOG_MAX_READS_PER_ITER'(1);
        end
      end

      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + LOG_FIFO_DEPTH'(1);
        data_out_q <= mem[rd_ptr_q];
        addr_out_q <= cur_addr_q;
        if (wr_last) begin
          wr_cnt_q    <= '0;
          iter_base_q <= iter_base_q + stride_q;
          cur_addr_q  <= iter_base_q + stride_q;
        end else begin
          wr_cnt_q   <= wr_cnt_q + LOG_MAX_READS_PER_ITER'(1);
          cur_addr_q <= cur_addr_q + LOG_MAX_ADDRESS'(1);
        end
      end

      case ({accept, pop})
        2'b10:   count_q <= count_q + (LOG_FIFO_DEPTH+1)'(1);
        2'b01:   count_q <= count_q - (LOG_FIFO_DEPTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.valid_out   = valid_out_q;
  assign bus.data_out    = data_out_q;
  assign bus.address_out = addr_out_q;
  assign busy_out        = (state_q != IDLE);
  assign done_out        = done_q;

`ifdef WRITE_MC_CLIP_COUNT_EN
  function automatic logic lane_clipped(
    input logic signed [IW-1:0] v,
    input logic signed [OW-1:0] lo,
    input logic signed [OW-1:0] hi
  );
    return (v < IW'(lo)) || (v > IW'(hi));
  endfunction

  logic [LOG_MAX_ADDRESS-1:0] clip_cnt_q;
  logic [LOG_MAX_ADDRESS:0]   clip_sum;

  // One extra bit catches the overflow that drives saturation.
  always_comb begin
    clip_sum = {1'b0, clip_cnt_q};
    for (int k = 0; k < NUM_CH; k++) begin
      if (lane_clipped($signed(bus.data_in[k*IW +: IW]), min_q, max_q))
        clip_sum = clip_sum + (LOG_MAX_ADDRESS+1)'(1);
    end
  end

  // ---- stage: clip statistics ----
  always_ff @(posedge clk) begin
    if (!rst)          clip_cnt_q <= '0;
    else if (cfg_take) clip_cnt_q <= '0;
    else if (accept)   clip_cnt_q <= clip_sum[LOG_MAX_ADDRESS] ? '1
                                                               : clip_sum[LOG_MAX_ADDRESS-1:0];
  end

  assign clip_count_out = clip_cnt_q;
`endif

endmodule

// File: tb/tb_write_mc.sv
module tb_write_mc;
  localparam int NCH = 8;
  localparam int IW  = 16;
  localparam int OW  = 8;
  localparam int AW  = 16;

  logic clk = 1'b0;
  logic rst;
  logic configure;
  logic [15:0] num_iters, num_reads_per_iter;
  logic [AW-1:0] base_address, iter_stride;
  logic signed [OW-1:0] min_clip, max_clip;
  logic busy_out, done_out;
`ifdef WRITE_MC_CLIP_COUNT_EN
  logic [AW-1:0] clip_count_out;
`endif

  write_mc_if #(.NUM_CH(NCH), .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW),
                .LOG_MAX_ADDRESS(AW)) bus ();

  write_mc dut (
    .clk(clk), .rst(rst), .configure(configure),
    .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
    .base_address(base_address), .iter_stride(iter_stride),
    .min_clip(min_clip), .max_clip(max_clip),
    .bus(bus), .busy_out(busy_out), .done_out(done_out)
`ifdef WRITE_MC_CLIP_COUNT_EN
    , .clip_count_out(clip_count_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_valid_cyc = -1;
  logic [AW-1:0]     addr_log[$];
  logic [NCH*OW-1:0] data_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      addr_log.push_back(bus.address_out);
      data_log.push_back(bus.data_out);
      last_valid_cyc = cyc;
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NCH*IW-1:0] mk_in(input int j);
    logic [NCH*IW-1:0] w;
    for (int k = 0; k < NCH; k++) w[k*IW +: IW] = IW'(j*8 + k - 64);
    return w;
  endfunction

  function automatic logic [NCH*OW-1:0] mk_out(input int j);
    logic [NCH*OW-1:0] w;
    for (int k = 0; k < NCH; k++) w[k*OW +: OW] = OW'(j*8 + k - 64);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int iters, input int reads, input logic [AW-1:0] base,
                     input logic [AW-1:0] stride, input logic signed [OW-1:0] lo,
                     input logic signed [OW-1:0] hi);
    num_iters = 16'(iters);
    num_reads_per_iter = 16'(reads);
    base_address = base;
    iter_stride = stride;
    min_clip = lo;
    max_clip = hi;
    configure = 1'b1;
    tick();
    configure = 1'b0;
  endtask

  task automatic send(input logic [NCH*IW-1:0] w);
    int n = 0;
    bus.data_in = w;
    bus.valid_in = 1'b1;
    while (bus.avail_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, output bit ok);
    int n = 0;
    while (done_cnt == start_cnt && n < 200) begin
      tick();
      n++;
    end
    ok = (done_cnt != start_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    configure = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.data_in = '0;
    num_iters = '0; num_reads_per_iter = '0;
    base_address = '0; iter_stride = '0;
    min_clip = '0; max_clip = '0;
    tick(); tick();
    total++;
    if ({bus.avail_out, bus.valid_out, busy_out, done_out} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {bus.avail_out, bus.valid_out, busy_out, done_out});
    end
    total++;
    if (bus.data_out !== '0 || bus.address_out !== '0) begin
      bad++;
      $display("FAIL reset_data: data %h addr %h want 0", bus.data_out, bus.address_out);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    addr_log.delete(); data_log.delete();
    d0 = done_cnt;
    bus.ready_in = 1'b1;
    cfg(2, 4, 16'h0010, 16'h0020, -8'sd128, 8'sd127);
    total++;
    if (busy_out !== 1'b1) begin
      bad++; $display("FAIL basic_busy: got %b want 1", busy_out);
    end
    for (int i = 0; i < 8; i++) send(mk_in(i));
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done_timeout: no done pulse"); end
    tick(); tick();
    total++;
    if (addr_log.size() != 8) begin
      bad++; $display("FAIL basic_count: got %0d writes want 8", addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (addr_log[i] !== AW'(16'h10 + (i/4)*16'h20 + (i%4)) || data_log[i] !== mk_out(i)) begin
          bad++;
          $display("FAIL basic_write%0d: addr %h data %h want addr %h data %h", i,
                   addr_log[i], data_log[i], AW'(16'h10 + (i/4)*16'h20 + (i%4)), mk_out(i));
        end
      end
    end
    total++;
    if (done_cnt - d0 != 1 || done_cyc != last_valid_cyc + 1) begin
      bad++;
      $display("FAIL basic_done_timing: pulses %0d at %0d last valid %0d want 1 at last+1",
               done_cnt - d0, done_cyc, last_valid_cyc);
    end
    total++;
    if (busy_out !== 1'b0 || bus.data_out !== mk_out(7)) begin
      bad++;
      $display("FAIL basic_idle_hold: busy %b data %h want 0 / %h", busy_out, bus.data_out, mk_out(7));
    end
  endtask

  task automatic test_clip();
    bit ok;
    int d0;
    logic [NCH*IW-1:0] w_in;
    logic [NCH*OW-1:0] w_exp;
    w_in  = 128'h00C8_FFFB_0005_0000_FF80_007F_FED4_012C;
    w_exp = 64'h64FB_0500_9C64_9C64;
    d0 = done_cnt;
    bus.ready_in = 1'b1;
    cfg(1, 1, 16'h0040, 16'h0000, -8'sd100, 8'sd100);
    send(w_in);
    total++;
    if (bus.valid_out !== 1'b0) begin
      bad++; $display("FAIL clip_latency_early: valid_out %b want 0", bus.valid_out);
    end
    tick();
    total++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== w_exp || bus.address_out !== 16'h0040) begin
      bad++;
      $display("FAIL clip_word: valid %b data %h addr %h want 1 %h 0040",
               bus.valid_out, bus.data_out, bus.address_out, w_exp);
    end
`ifdef WRITE_MC_CLIP_COUNT_EN
    total++;
    if (clip_count_out !== 16'd5) begin
      bad++; $display("FAIL clip_count: got %0d want 5", clip_count_out);
    end
`endif
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL clip_done_timeout: no done pulse"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int d0;
    int acc = 0;
    bit acc_now;
    addr_log.delete(); data_log.delete();
    d0 = done_cnt;
    bus.ready_in = 1'b0;
    cfg(1, 20, 16'h0100, 16'h0000, -8'sd128, 8'sd127);
    bus.valid_in = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.data_in = mk_in(acc);
      acc_now = (bus.avail_out === 1'b1);
      tick();
      if (acc_now) acc++;
    end
    bus.valid_in = 1'b0;
    total++;
    if (acc != 16 || bus.avail_out !== 1'b0) begin
      bad++; $display("FAIL bp_fill: accepts %0d avail %b want 16 / 0", acc, bus.avail_out);
    end
    total++;
    if (addr_log.size() != 0) begin
      bad++; $display("FAIL bp_no_write: got %0d writes want 0", addr_log.size());
    end
    bus.ready_in = 1'b1;
    for (int j = 16; j < 20; j++) send(mk_in(j));
    wait_done(d0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_done_timeout: no done pulse"); end
    tick();
    total++;
    if (addr_log.size() != 20) begin
      bad++; $display("FAIL bp_count: got %0d writes want 20", addr_log.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        total++;
        if (addr_log[i] !== AW'(16'h0100 + i) || data_log[i] !== mk_out(i)) begin
          bad++;
          $display("FAIL bp_write%0d: addr %h data %h want addr %h data %h", i,
                   addr_log[i], data_log[i], AW'(16'h0100 + i), mk_out(i));
        end
      end
    end
  endtask

  task automatic test_degenerate();
    int n0;
    addr_log.delete(); data_log.delete();
    n0 = done_cnt;
    cfg(0, 4, 16'h0200, 16'h0010, -8'sd128, 8'sd127);
    total++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      bad++; $display("FAIL degen_cycle1: busy %b done %b want 0 0", busy_out, done_out);
    end
    tick();
    total++;
    if (done_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++; $display("FAIL degen_pulse: done %b busy %b want 1 0", done_out, busy_out);
    end
    tick(); tick();
    total++;
    if (done_cnt - n0 != 1 || addr_log.size() != 0 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL degen_after: pulses %0d writes %0d busy %b want 1 0 0",
               done_cnt - n0, addr_log.size(), busy_out);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    int d0;
    logic [AW-1:0] exp_a[4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    addr_log.delete(); data_log.delete();
    d0 = done_cnt;
    bus.ready_in = 1'b1;
    cfg(1, 4, 16'hFFFE, 16'h0000, -8'sd128, 8'sd127);
    for (int i = 0; i < 4; i++) send(mk_in(i + 3));
    wait_done(d0, ok);
    tick();
    total++;
    if (!ok || addr_log.size() != 4) begin
      bad++; $display("FAIL wrap_count: done %0d writes %0d want 1 4", ok, addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr_log[i] !== exp_a[i]) begin
          bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_log[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nw, nd;
    bit saw_avail = 1'b0;
    bus.ready_in = 1'b1;
    cfg(2, 4, 16'h0010, 16'h0020, -8'sd128, 8'sd127);
    for (int i = 0; i < 3; i++) send(mk_in(i));
    nd = done_cnt;
    rst = 1'b0;
    tick();
    total++;
    if ({bus.avail_out, bus.valid_out, busy_out, done_out} !== 4'b0000 ||
        bus.data_out !== '0 || bus.address_out !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: ctrl %b data %h addr %h want all 0",
               {bus.avail_out, bus.valid_out, busy_out, done_out}, bus.data_out, bus.address_out);
    end
    rst = 1'b1;
    nw = addr_log.size();
    bus.valid_in = 1'b1;
    bus.data_in = mk_in(9);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.avail_out === 1'b1) saw_avail = 1'b1;
    end
    bus.valid_in = 1'b0;
    total++;
    if (addr_log.size() != nw || done_cnt != nd || saw_avail || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: new writes %0d new dones %0d avail %b busy %b want 0 0 0 0",
               addr_log.size() - nw, done_cnt - nd, saw_avail, busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_backpressure();
    test_degenerate();
    test_addr_wrap();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
